// File: rtl/ad936x_rx_deframer.sv
// ad936x_rx_deframer
//   Reassembles AD936x DDR LVDS receive words into I/Q sample sets and
//   tracks frame alignment with a SEARCH / CHECK / LOCKED state machine.
//
// Ports
//   data_clk              sole clock, one DDR-captured word per enabled cycle
//   rst                   asynchronous, active-high reset
//   rx_en                 word valid / clock enable; all state holds when low
//   rx_data_h, rx_data_l  rising / falling edge captures (word MSBs / LSBs)
//   rx_frame_h/l          frame bit captured on rising / falling edge
//   mode_2r2t             0 = 1R1T (I1,Q1), 1 = 2R2T (I1,Q1,I2,Q2)
//   err_clr               synchronous clear of err_cnt
//   adc_valid             one-cycle pulse per completed good sample set
//   adc_data_i1..q2       assembled samples, held between pulses
//   rx_status             high while LOCKED
//   err_cnt               saturating count of bad frames seen while LOCKED
module ad936x_rx_deframer #(
   parameter int unsigned HALF_W     = 6,
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_ERR = 2,
   parameter int unsigned ERR_W      = 16
) (
   input  logic                  data_clk,
   input  logic                  rst,
   input  logic                  rx_en,
   input  logic [HALF_W-1:0]     rx_data_h,
   input  logic [HALF_W-1:0]     rx_data_l,
   input  logic                  rx_frame_h,
   input  logic                  rx_frame_l,
   input  logic                  mode_2r2t,
   input  logic                  err_clr,
   output logic                  adc_valid,
   output logic [2*HALF_W-1:0]   adc_data_i1,
   output logic [2*HALF_W-1:0]   adc_data_q1,
   output logic [2*HALF_W-1:0]   adc_data_i2,
   output logic [2*HALF_W-1:0]   adc_data_q2,
   output logic                  rx_status,
   output logic [ERR_W-1:0]      err_cnt
);

   localparam int unsigned SW  = 2 * HALF_W;
   localparam int unsigned CW  = 4;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t          state;
   logic [1:0]      pos;
   logic [CW-1:0]   good_cnt;
   logic [CW-1:0]   bad_cnt;
   logic            prev_f;
   logic            frame_bad;
   logic            mode_r;
   logic [SW-1:0]   w0, w1, w2;

   logic [SW-1:0]   word;
   logic            f;
   logic            word_bad;
   logic            exp_f;
   logic            at_last;
   logic            frame_bad_nxt;
   logic            mode_chg;

   // Per-word decode: frame bit expectation and badness of the current slot
   always_comb begin
      word          = {rx_data_h, rx_data_l};
      f             = rx_frame_h;
      word_bad      = rx_frame_h ^ rx_frame_l;
      exp_f         = mode_r ? (pos < 2'd2) : (pos == 2'd0);
      at_last       = mode_r ? (pos == 2'd3) : (pos == 2'd1);
      frame_bad_nxt = frame_bad | word_bad | (f != exp_f);
      mode_chg      = mode_2r2t != mode_r;
   end

   // Alignment FSM, sample assembly and error counting
   always_ff @(posedge data_clk or posedge rst) begin
      if (rst) begin
         state       <= SEARCH;
         pos         <= 2'd0;
         good_cnt    <= '0;
         bad_cnt     <= '0;
         prev_f      <= 1'b0;
         frame_bad   <= 1'b0;
         mode_r      <= 1'b0;
         w0          <= '0;
         w1          <= '0;
         w2          <= '0;
         adc_valid   <= 1'b0;
         adc_data_i1 <= '0;
         adc_data_q1 <= '0;
         adc_data_i2 <= '0;
         adc_data_q2 <= '0;
         rx_status   <= 1'b0;
         err_cnt     <= '0;
      end else begin
         adc_valid <= 1'b0;
         if (rx_en) begin
            prev_f <= f;
            if (mode_chg) begin
               // New frame period: drop the partial frame and realign
               mode_r    <= mode_2r2t;
               state     <= SEARCH;
               pos       <= 2'd0;
               frame_bad <= 1'b0;
               good_cnt  <= '0;
               bad_cnt   <= '0;
               rx_status <= 1'b0;
            end else begin
               case (state)
                  SEARCH: begin
                     // Rising edge of the frame bit marks slot 0
                     if (f && !prev_f) begin
                        state     <= CHECK;
                        pos       <= 2'd1;
                        frame_bad <= word_bad;
                        w0        <= word;
                        good_cnt  <= '0;
                     end
                  end
                  CHECK, LOCKED: begin
                     if (!at_last) begin
                        pos       <= pos + 2'd1;
                        frame_bad <= frame_bad_nxt;
                        case (pos)
                           2'd0:    w0 <= word;
                           2'd1:    w1 <= word;
                           default: w2 <= word;
                        endcase
                     end else begin
                        pos       <= 2'd0;
                        frame_bad <= 1'b0;
                        if (state == CHECK) begin
                           if (frame_bad_nxt) begin
                              state <= SEARCH;
                           end else if (good_cnt + 4'd1 == CW'(LOCK_CNT)) begin
                              // Lock-completing frame produces no pulse
                              state     <= LOCKED;
                              rx_status <= 1'b1;
                              bad_cnt   <= '0;
                           end else begin
                              good_cnt <= good_cnt + 4'd1;
                           end
                        end else if (!frame_bad_nxt) begin
                           adc_valid   <= 1'b1;
                           bad_cnt     <= '0;
                           adc_data_i1 <= w0;
                           if (mode_r) begin
                              adc_data_q1 <= w1;
                              adc_data_i2 <= w2;
                              adc_data_q2 <= word;
                           end else begin
                              adc_data_q1 <= word;
                              adc_data_i2 <= '0;
                              adc_data_q2 <= '0;
                           end
                        end else begin
                           if (err_cnt != '1)
                              err_cnt <= err_cnt + ERR_W'(1);
                           if (bad_cnt + 4'd1 == CW'(UNLOCK_ERR)) begin
                              state     <= SEARCH;
                              rx_status <= 1'b0;
                           end else begin
                              bad_cnt <= bad_cnt + 4'd1;
                           end
                        end
                     end
                  end
                  default: state <= SEARCH;
               endcase
            end
         end
         // Clear takes priority over a same-cycle increment
         if (err_clr)
            err_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_ad936x_rx_deframer.sv
// Testbench for ad936x_rx_deframer: frame-level reference model with
// randomized data, corruption, rx_en gaps and mode changes.
module tb_ad936x_rx_deframer;

   localparam int unsigned HALF_W     = 6;
   localparam int unsigned SW         = 2 * HALF_W;
   localparam int unsigned LOCK_CNT   = 4;
   localparam int unsigned UNLOCK_ERR = 2;
   localparam int unsigned ERR_W      = 4;
   localparam int          ERR_MAX    = (1 << ERR_W) - 1;

   logic              data_clk = 1'b0;
   logic              rst = 1'b1;
   logic              rx_en = 1'b0;
   logic [HALF_W-1:0] rx_data_h = '0;
   logic [HALF_W-1:0] rx_data_l = '0;
   logic              rx_frame_h = 1'b0;
   logic              rx_frame_l = 1'b0;
   logic              mode_2r2t = 1'b0;
   logic              err_clr = 1'b0;
   logic              adc_valid;
   logic [SW-1:0]     adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2;
   logic              rx_status;
   logic [ERR_W-1:0]  err_cnt;

   int checks = 0;
   int errors = 0;

   // Frame-level reference state
   bit            m_locked = 0;
   int            m_good = 0;
   int            m_bad = 0;
   int            m_err = 0;
   logic [SW-1:0] m_d [4] = '{default: '0};

   // Observations from the most recent frame
   bit            obs_mid;
   bit            obs_last;

   ad936x_rx_deframer #(
      .HALF_W(HALF_W), .LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .ERR_W(ERR_W)
   ) dut (
      .data_clk(data_clk), .rst(rst), .rx_en(rx_en),
      .rx_data_h(rx_data_h), .rx_data_l(rx_data_l),
      .rx_frame_h(rx_frame_h), .rx_frame_l(rx_frame_l),
      .mode_2r2t(mode_2r2t), .err_clr(err_clr),
      .adc_valid(adc_valid),
      .adc_data_i1(adc_data_i1), .adc_data_q1(adc_data_q1),
      .adc_data_i2(adc_data_i2), .adc_data_q2(adc_data_q2),
      .rx_status(rx_status), .err_cnt(err_cnt)
   );

   always #5 data_clk = ~data_clk;

   task automatic send_word(input logic [SW-1:0] w, input logic fh, input logic fl);
      rx_en      = 1'b1;
      rx_data_h  = w[SW-1:HALF_W];
      rx_data_l  = w[HALF_W-1:0];
      rx_frame_h = fh;
      rx_frame_l = fl;
      @(posedge data_clk);
      #1;
   endtask

   task automatic model_reset();
      m_locked = 0;
      m_good   = 0;
      m_bad    = 0;
   endtask

   // One whole frame: lock progression, pulse decision, error counting
   task automatic model_frame(input bit bad, input bit clr, output bit p);
      p = 0;
      if (!m_locked) begin
         if (bad) m_good = 0;
         else begin
            m_good++;
            if (m_good == LOCK_CNT) begin
               m_locked = 1;
               m_bad    = 0;
            end
         end
      end else if (!bad) begin
         p     = 1;
         m_bad = 0;
      end else begin
         if (m_err < ERR_MAX) m_err++;
         m_bad++;
         if (m_bad == UNLOCK_ERR) begin
            m_locked = 0;
            m_good   = 0;
         end
      end
      if (clr) m_err = 0;
   endtask

   // Drive one frame in the current mode; bad_pos flips rx_frame_l there,
   // pat_err drops the frame bit of slot 1 in 2R2T
   task automatic run_frame(input logic [SW-1:0] d0, input logic [SW-1:0] d1,
                            input logic [SW-1:0] d2, input logic [SW-1:0] d3,
                            input int bad_pos, input bit pat_err,
                            input bit clr, input bit gaps);
      logic [SW-1:0] d [4];
      int n;
      logic fh, fl;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      n = mode_2r2t ? 4 : 2;
      obs_mid = 0;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            rx_en      = 1'b0;
            rx_data_h  = HALF_W'($urandom);
            rx_data_l  = HALF_W'($urandom);
            rx_frame_h = 1'($urandom);
            rx_frame_l = 1'($urandom);
            repeat ($urandom_range(1, 3)) begin
               @(posedge data_clk);
               #1;
               if (adc_valid) obs_mid = 1;
            end
         end
         fh = (i < n / 2);
         if (pat_err && n == 4 && i == 1) fh = 1'b0;
         fl = fh ^ (i == bad_pos);
         err_clr = clr && (i == n - 1);
         send_word(d[i], fh, fl);
         err_clr = 1'b0;
         if (i < n - 1 && adc_valid) obs_mid = 1;
      end
      obs_last = adc_valid;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge data_clk);
      #1;
      checks++;
      if (adc_valid !== 1'b0 || rx_status !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got valid=%0b status=%0b want 0 0", adc_valid, rx_status);
      end
      checks++;
      if (err_cnt !== '0) begin
         errors++;
         $display("FAIL reset_err got %0d want 0", err_cnt);
      end
      checks++;
      if ({adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2} !== '0) begin
         errors++;
         $display("FAIL reset_data got %h %h %h %h want 0", adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2);
      end
      rst = 1'b0;
   endtask

   task automatic test_1r1t_lock();
      bit p;
      mode_2r2t = 1'b0;
      send_word('0, 1'b0, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         run_frame(12'hABC, 12'h123, '0, '0, -1, 0, 0, 0);
         model_frame(0, 0, p);
         checks++;
         if (rx_status !== (k >= 4)) begin
            errors++;
            $display("FAIL 1r1t_status frame %0d got %0b want %0b", k, rx_status, (k >= 4));
         end
         checks++;
         if (obs_last !== (k >= 5) || obs_mid) begin
            errors++;
            $display("FAIL 1r1t_pulse frame %0d got last=%0b mid=%0b want %0b 0", k, obs_last, obs_mid, (k >= 5));
         end
         if (k >= 5) begin
            checks++;
            if ({adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2} !== {12'hABC, 12'h123, 24'h0}) begin
               errors++;
               $display("FAIL 1r1t_data got %h %h %h %h want abc 123 0 0", adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2);
            end
         end
      end
      m_d = '{12'hABC, 12'h123, '0, '0};
   endtask

   task automatic test_2r2t();
      bit p;
      mode_2r2t = 1'b1;
      send_word('0, 1'b0, 1'b0);
      model_reset();
      checks++;
      if (rx_status !== 1'b0) begin
         errors++;
         $display("FAIL 2r2t_mode_status got %0b want 0", rx_status);
      end
      for (int k = 1; k <= 6; k++) begin
         run_frame(12'h111, 12'h222, 12'h333, 12'h444, -1, 0, 0, 0);
         model_frame(0, 0, p);
         checks++;
         if (obs_last !== (k >= 5) || obs_mid || rx_status !== (k >= 4)) begin
            errors++;
            $display("FAIL 2r2t_frame %0d got last=%0b mid=%0b status=%0b want %0b 0 %0b",
                     k, obs_last, obs_mid, rx_status, (k >= 5), (k >= 4));
         end
      end
      checks++;
      if ({adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2} !== {12'h111, 12'h222, 12'h333, 12'h444}) begin
         errors++;
         $display("FAIL 2r2t_data got %h %h %h %h want 111 222 333 444", adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2);
      end
      m_d = '{12'h111, 12'h222, 12'h333, 12'h444};
   endtask

   task automatic test_bad_frame();
      bit p;
      run_frame(12'h111, 12'h222, 12'h333, 12'h444, int'($urandom_range(0, 3)), 0, 0, 0);
      model_frame(1, 0, p);
      checks++;
      if (obs_last !== 1'b0 || err_cnt !== 4'd1 || rx_status !== 1'b1) begin
         errors++;
         $display("FAIL bad_one got valid=%0b err=%0d status=%0b want 0 1 1", obs_last, err_cnt, rx_status);
      end
      checks++;
      if ({adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2} !== {12'h111, 12'h222, 12'h333, 12'h444}) begin
         errors++;
         $display("FAIL bad_hold got %h %h %h %h want 111 222 333 444", adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2);
      end
      run_frame(12'h5A5, 12'hA5A, 12'h0F0, 12'hF0F, -1, 0, 0, 0);
      model_frame(0, 0, p);
      checks++;
      if (obs_last !== 1'b1 || {adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2} !== {12'h5A5, 12'hA5A, 12'h0F0, 12'hF0F}) begin
         errors++;
         $display("FAIL bad_recover got valid=%0b data %h %h %h %h want 1 5a5 a5a 0f0 f0f",
                  obs_last, adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2);
      end
      m_d = '{12'h5A5, 12'hA5A, 12'h0F0, 12'hF0F};
      rx_en = 1'b0;
      err_clr = 1'b1;
      @(posedge data_clk);
      #1;
      err_clr = 1'b0;
      m_err = 0;
      checks++;
      if (err_cnt !== '0) begin
         errors++;
         $display("FAIL err_clr got %0d want 0", err_cnt);
      end
      run_frame(12'h001, 12'h002, 12'h003, 12'h004, -1, 1, 0, 0);
      model_frame(1, 0, p);
      run_frame(12'h001, 12'h002, 12'h003, 12'h004, 2, 0, 0, 0);
      model_frame(1, 0, p);
      checks++;
      if (rx_status !== 1'b0 || err_cnt !== 4'd2 || obs_last !== 1'b0) begin
         errors++;
         $display("FAIL unlock got status=%0b err=%0d valid=%0b want 0 2 0", rx_status, err_cnt, obs_last);
      end
   endtask

   task automatic test_mode_toggle();
      bit p;
      for (int k = 0; k < 5; k++) begin
         run_frame(12'h777, 12'h888, 12'h999, 12'hAAA, -1, 0, 0, 0);
         model_frame(0, 0, p);
      end
      m_d = '{12'h777, 12'h888, 12'h999, 12'hAAA};
      checks++;
      if (rx_status !== 1'b1 || obs_last !== 1'b1) begin
         errors++;
         $display("FAIL toggle_prelock got status=%0b valid=%0b want 1 1", rx_status, obs_last);
      end
      send_word(12'h777, 1'b1, 1'b1);
      send_word(12'h888, 1'b1, 1'b1);
      mode_2r2t = 1'b0;
      send_word(12'h999, 1'b0, 1'b0);
      model_reset();
      checks++;
      if (rx_status !== 1'b0 || adc_valid !== 1'b0) begin
         errors++;
         $display("FAIL toggle_status got status=%0b valid=%0b want 0 0", rx_status, adc_valid);
      end
      for (int k = 1; k <= 5; k++) begin
         run_frame(12'h246, 12'h8AC, '0, '0, -1, 0, 0, 0);
         model_frame(0, 0, p);
         checks++;
         if (obs_last !== (k == 5) || obs_mid || rx_status !== (k >= 4)) begin
            errors++;
            $display("FAIL toggle_relock frame %0d got last=%0b mid=%0b status=%0b want %0b 0 %0b",
                     k, obs_last, obs_mid, rx_status, (k == 5), (k >= 4));
         end
      end
      m_d = '{12'h246, 12'h8AC, '0, '0};
   endtask

   task automatic test_err_sat();
      bit p;
      for (int k = 0; k < 17; k++) begin
         run_frame(12'h100, 12'h200, '0, '0, int'($urandom_range(0, 1)), 0, 0, 0);
         model_frame(1, 0, p);
         run_frame(12'h300, 12'h400, '0, '0, -1, 0, 0, 0);
         model_frame(0, 0, p);
      end
      m_d = '{12'h300, 12'h400, '0, '0};
      checks++;
      if (err_cnt !== 4'(ERR_MAX) || rx_status !== 1'b1) begin
         errors++;
         $display("FAIL err_sat got err=%0d status=%0b want %0d 1", err_cnt, rx_status, ERR_MAX);
      end
      run_frame(12'h100, 12'h200, '0, '0, 1, 0, 1, 0);
      model_frame(1, 1, p);
      checks++;
      if (err_cnt !== '0) begin
         errors++;
         $display("FAIL err_clr_wins got %0d want 0", err_cnt);
      end
   endtask

   task automatic test_random();
      bit p, bad, pat, clr;
      int bp, n;
      logic [SW-1:0] d [4];
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            mode_2r2t = ~mode_2r2t;
            send_word(SW'($urandom), 1'b0, 1'b0);
            model_reset();
            checks++;
            if (rx_status !== 1'b0) begin
               errors++;
               $display("FAIL rand_toggle iter %0d got status=%0b want 0", k, rx_status);
            end
         end
         n = mode_2r2t ? 4 : 2;
         for (int i = 0; i < 4; i++) d[i] = SW'($urandom);
         bp  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         pat = (n == 4) && ($urandom_range(0, 7) == 0);
         clr = ($urandom_range(0, 19) == 0);
         bad = (bp >= 0) || pat;
         run_frame(d[0], d[1], d[2], d[3], bp, pat, clr, 1);
         model_frame(bad, clr, p);
         if (p) begin
            m_d[0] = d[0];
            m_d[1] = d[1];
            m_d[2] = (n == 4) ? d[2] : '0;
            m_d[3] = (n == 4) ? d[3] : '0;
         end
         checks++;
         if (obs_last !== p || obs_mid || rx_status !== m_locked || int'(err_cnt) != m_err) begin
            errors++;
            $display("FAIL rand_frame iter %0d got last=%0b mid=%0b status=%0b err=%0d want %0b 0 %0b %0d",
                     k, obs_last, obs_mid, rx_status, err_cnt, p, m_locked, m_err);
         end
         checks++;
         if ({adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2} !== {m_d[0], m_d[1], m_d[2], m_d[3]}) begin
            errors++;
            $display("FAIL rand_data iter %0d got %h %h %h %h want %h %h %h %h", k,
                     adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2, m_d[0], m_d[1], m_d[2], m_d[3]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      bit p;
      for (int k = 0; k < int'(LOCK_CNT) + 1; k++) begin
         run_frame(12'hCAF, 12'hE00, 12'h135, 12'h79B, -1, 0, 0, 0);
         model_frame(0, 0, p);
      end
      send_word(12'hDEA, 1'b1, 1'b1);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (adc_valid !== 1'b0 || rx_status !== 1'b0 || err_cnt !== '0 ||
          {adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2} !== '0) begin
         errors++;
         $display("FAIL rst_mid got valid=%0b status=%0b err=%0d data %h %h %h %h want all 0",
                  adc_valid, rx_status, err_cnt, adc_data_i1, adc_data_q1, adc_data_i2, adc_data_q2);
      end
      @(posedge data_clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         rx_en      = 1'b0;
         rx_data_h  = HALF_W'($urandom);
         rx_data_l  = HALF_W'($urandom);
         rx_frame_h = 1'(c % 2);
         rx_frame_l = 1'(c % 2);
         @(posedge data_clk);
         #1;
         checks++;
         if (adc_valid !== 1'b0 || rx_status !== 1'b0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL rst_hold cycle %0d got valid=%0b status=%0b err=%0d want 0 0 0", c, adc_valid, rx_status, err_cnt);
         end
      end
      model_reset();
      m_err = 0;
      send_word('0, 1'b0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         run_frame(12'h0AA, 12'h055, 12'h0CC, 12'h033, -1, 0, 0, 0);
         model_frame(0, 0, p);
         checks++;
         if (obs_last !== (k == 5) || obs_mid || rx_status !== (k >= 4)) begin
            errors++;
            $display("FAIL rst_relock frame %0d got last=%0b mid=%0b status=%0b want %0b 0 %0b",
                     k, obs_last, obs_mid, rx_status, (k == 5), (k >= 4));
         end
      end
   endtask

   initial begin
      test_reset();
      test_1r1t_lock();
      test_2r2t();
      test_bad_frame();
      test_mode_toggle();
      test_err_sat();
      test_random();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
